apb_master_arb: RTL and testbench

Multi-requester APB master: accepts transaction requests from NREQ internal requesters, arbitrates among them round-robin, and sequences one APB transfer at a time (SETUP, ACCESS, wait for PREADY) onto a single shared APB bus that drives `apb_slave`. It returns read data, or an error on bus timeout, to the granted requester. It sits between on-chip masters (CPU shim, DMA, test sequencer) and the peripheral APB segment.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_rr_arbiter.sv | 33 +++
 rtl/apb_master_arb.sv | 110 +++++++++++
 tb/tb_apb_master_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and width helpers for the multi-requester APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Timeout counter width; a disabled timeout (0) still gets a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
// No state; the owner of ptr advances it on a grant.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin multi-requester APB master: one transfer at a time, 3-cycle minimum
// request-to-response latency plus one per wait state, optional PREADY timeout.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]              req_accept,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_WIDTH-1:0]        PADDR,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [DATA_WIDTH-1:0]        PWDATA,
  input  logic [DATA_WIDTH-1:0]        PRDATA,
  input  logic                         PREADY
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TMAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  apb_state_e      state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            timeout_hit;

  apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TMAX);

  // ptr always holds the index of the requester currently on the bus.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= IDLE;
      ptr        <= IW'(NREQ - 1);
      cnt        <= '0;
      req_accept <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
    end else begin
      req_accept <= '0;
      rsp_valid  <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state      <= SETUP;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            PWRITE     <= req_write[gidx];
            PADDR      <= req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            PWDATA     <= req_write[gidx] ? req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
            req_accept <= grant;
            ptr        <= gidx;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          cnt     <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NREQ'(1) << ptr;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end else if (timeout_hit) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NREQ'(1) << ptr;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a small memory-backed APB slave model.
module tb_apb_master_arb;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 2;

  logic            PCLK;
  logic            PRESETn;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   req_accept;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   PADDR;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;

  int n_checks = 0;
  int n_err    = 0;

  // slave model controls
  int   wait_states = 0;
  logic stuck       = 1'b0;
  int   acc_cnt     = 0;
  logic [DW-1:0] mem [256];

  apb_master_arb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NREQ       (NR),
    .TIMEOUT    (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_accept (req_accept),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign PREADY = PSEL && PENABLE && !stuck && (acc_cnt >= wait_states);
  assign PRDATA = mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]            = 1'b1;
    req_write[r]            = wr;
    req_addr[r*AW +: AW]    = a;
    req_wdata[r*DW +: DW]   = d;
  endtask

  // Runs until a response; drops valid on accept, reports latency, ACCESS cycles
  // and whether the bus payload stayed put while PSEL was high.
  task automatic wait_rsp(input int bound, output int lat, output int acc, output bit stable);
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          w0;
    bit            seen;
    lat = 0; acc = 0; stable = 1'b1; seen = 1'b0;
    a0 = '0; d0 = '0; w0 = 1'b0;
    do begin
      tick();
      lat++;
      req_valid = req_valid & ~req_accept;
      if (PSEL) begin
        if (!seen) begin a0 = PADDR; d0 = PWDATA; w0 = PWRITE; seen = 1'b1; end
        else if (PADDR !== a0 || PWDATA !== d0 || PWRITE !== w0) stable = 1'b0;
      end
      if (PSEL && PENABLE) acc++;
    end while (rsp_valid == '0 && lat < bound);
    if (rsp_valid == '0) begin
      n_checks++;
      n_err++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", bound);
    end
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    tick();
    tick();
    PRESETn = 1'b1;
  endtask

  int lat, acc;
  bit stable;
  logic [NR-1:0] exp_order [4];
  int cyc;

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    do_reset();
    check("rst_psel",   PSEL, 0);
    check("rst_pen",    PENABLE, 0);
    check("rst_accept", req_accept, 0);
    check("rst_rsp",    rsp_valid, 0);

    // single zero-wait write, cycle by cycle
    issue(0, 1'b1, 8'h10, 32'hA5A5A5A5);
    tick();
    check("w_c1_psel",   PSEL, 1);
    check("w_c1_pen",    PENABLE, 0);
    check("w_c1_accept", req_accept, 2'b01);
    check("w_c1_paddr",  PADDR, 8'h10);
    check("w_c1_pwdata", PWDATA, 32'hA5A5A5A5);
    check("w_c1_pwrite", PWRITE, 1);
    req_valid = '0;
    tick();
    check("w_c2_pen",    PENABLE, 1);
    check("w_c2_accept", req_accept, 0);
    tick();
    check("w_c3_rsp",    rsp_valid, 2'b01);
    check("w_c3_err",    rsp_err, 0);
    check("w_c3_psel",   PSEL, 0);
    check("w_c3_paddr",  PADDR, 8'h10);

    issue(0, 1'b0, 8'h10, 32'hFFFFFFFF);
    tick();
    check("r_pwdata0", PWDATA, 0);
    check("r_pwrite",  PWRITE, 0);
    wait_rsp(20, lat, acc, stable);
    check("r_lat",   lat + 1, 3);
    check("r_rdata", rsp_rdata, 32'hA5A5A5A5);

    // fairness: both continuously valid after reset
    do_reset();
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    issue(0, 1'b1, 8'h20, 32'h11111111);
    issue(1, 1'b1, 8'h30, 32'h12345678);
    for (int g = 0; g < 4; g++) begin
      cyc = 0;
      do begin tick(); cyc++; end while (req_accept == '0 && cyc < 10);
      check($sformatf("rr_grant%0d", g), req_accept, exp_order[g]);
    end
    req_valid = '0;
    wait_rsp(20, lat, acc, stable);
    issue(1, 1'b0, 8'h30, 32'h0);
    wait_rsp(20, lat, acc, stable);
    check("rr_rd1_rsp",   rsp_valid, 2'b10);
    check("rr_rd1_rdata", rsp_rdata, 32'h12345678);
    issue(0, 1'b0, 8'h20, 32'h0);
    wait_rsp(20, lat, acc, stable);
    check("rr_rd0_rdata", rsp_rdata, 32'h11111111);

    // three wait states
    wait_states = 3;
    issue(0, 1'b1, 8'h40, 32'hDEADBEEF);
    wait_rsp(20, lat, acc, stable);
    check("ws_lat",    lat, 6);
    check("ws_access", acc, 4);
    check("ws_stable", stable, 1);
    check("ws_err",    rsp_err, 0);
    check("ws_rsp",    rsp_valid, 2'b01);

    // timeout with PREADY stuck low
    stuck = 1'b1;
    issue(1, 1'b0, 8'h30, 32'h0);
    wait_rsp(20, lat, acc, stable);
    check("to_lat",    lat, 6);
    check("to_access", acc, 4);
    check("to_rsp",    rsp_valid, 2'b10);
    check("to_err",    rsp_err, 1);
    check("to_rdata",  rsp_rdata, 0);
    check("to_psel",   PSEL, 0);
    check("to_pen",    PENABLE, 0);
    stuck = 1'b0;
    wait_states = 0;
    issue(1, 1'b0, 8'h30, 32'h0);
    wait_rsp(20, lat, acc, stable);
    check("post_to_lat",   lat, 3);
    check("post_to_err",   rsp_err, 0);
    check("post_to_rdata", rsp_rdata, 32'h12345678);

    // reset during ACCESS
    stuck = 1'b1;
    issue(0, 1'b1, 8'h50, 32'hCAFEF00D);
    tick();
    req_valid = '0;
    tick();
    check("mid_in_access", PENABLE, 1);
    PRESETn = 1'b0;
    tick();
    check("mid_psel",   PSEL, 0);
    check("mid_pen",    PENABLE, 0);
    check("mid_pwrite", PWRITE, 0);
    check("mid_paddr",  PADDR, 0);
    check("mid_pwdata", PWDATA, 0);
    check("mid_rdata",  rsp_rdata, 0);
    check("mid_err",    rsp_err, 0);
    check("mid_rsp",    rsp_valid, 0);
    stuck = 1'b0;
    tick();
    PRESETn = 1'b1;
    check("mid_rsp2", rsp_valid, 0);
    issue(0, 1'b1, 8'h60, 32'h1);
    issue(1, 1'b1, 8'h61, 32'h2);
    tick();
    check("mid_first_grant", req_accept, 2'b01);
    req_valid[0] = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (req_accept == '0 && cyc < 10);
    check("mid_second_grant", req_accept, 2'b10);
    req_valid = '0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
